cache_lookup_ctrl: RTL and testbench
====================================

Name: cache_lookup_ctrl

Overview:
Direct-mapped, single-word-line cache controller that drives the valid-bit, tag and data arrays.
- Looks up each CPU access, stalls the CPU on a miss and refills from main memory over a req/ack handshake.
- Writes are write-through, no-write-allocate.
- The valid array is cleared by its own flash clear on rst. This block is the reader/writer of that array.

Parameters:
IDX_W, 9, index width; array depth 2**IDX_W (512); index = cpu_addr[IDX_W+1:2]
TAG_W, 21, tag width; tag = cpu_addr[31:IDX_W+2]
CNT_W, 16, width of the hit/miss performance counters

Ports:
clk  in  1  clock; state updates on posedge
rst  in  1  asynchronous, active-high reset
cpu_req  in  1  access request; held high with stable addr/data while cpu_stall=1
cpu_we  in  1  1=store, 0=load
cpu_addr  in  32  byte address, word aligned
cpu_wdata  in  32  store data
cpu_rdata  out  32  load data, valid when cpu_req & !cpu_we & !cpu_stall
cpu_stall  out  1  hold CPU pipeline
arr_idx  out  IDX_W  index to all three arrays (combinational read)
valid_in  in  1  valid bit at arr_idx
tag_in  in  TAG_W  tag at arr_idx
data_in  in  32  data word at arr_idx
valid_we  out  1  valid-array write strobe
valid_wdata  out  1  valid bit to write
tag_we  out  1  tag-array write strobe
data_we  out  1  data-array write strobe
tag_wdata  out  TAG_W  tag to write (= cpu_addr tag)
data_wdata  out  32  data to write
mem_req  out  1  memory request
mem_we  out  1  memory write
mem_addr  out  32  {cpu_addr[31:2],2'b00}
mem_wdata  out  32  = cpu_wdata
mem_ack  in  1  one-cycle completion pulse; mem_rdata valid with it
mem_rdata  in  32  refill data
flush  in  1  invalidate-all request (see Optional Feature)
hit_cnt  out  CNT_W  saturating load-hit count
miss_cnt  out  CNT_W  saturating load-miss count

Behaviour:
- Reset (async): state=IDLE; all outputs 0; counters 0; sweep counter 0.
- hit = valid_in & (tag_in == cpu_addr tag). arr_idx = cpu_addr index in every state except SWEEP.
- States: IDLE, RD_MISS, WR_THRU, SWEEP (last only with the macro).

IDLE:
- Load hit: cpu_rdata=data_in; cpu_stall=0 (zero-latency); hit_cnt+1.
- Load miss: cpu_stall=1 combinationally this cycle; miss_cnt+1; next state RD_MISS.
- Store: cpu_stall=1; if hit, data_we=1 with data_wdata=cpu_wdata in this cycle; next state WR_THRU.
- No cpu_req: stall=0, no strobes.

RD_MISS:
- mem_req=1, mem_we=0; cpu_stall=1.
- On mem_ack: valid_we=tag_we=data_we=1, valid_wdata=1, data_wdata=mem_rdata; next state IDLE.
- The next cycle re-looks-up and hits; this refill completion counts as a hit. Load-miss latency = ack cycle + 1.

WR_THRU:
- mem_req=1, mem_we=1, cpu_stall=1.
- On mem_ack: next state IDLE with stall=0 that cycle.
- Array writes are not repeated.

Handshake and boundary rules:
- mem_req stays high with stable mem_addr/mem_wdata until mem_ack; it drops the cycle after ack.
- mem_ack outside RD_MISS/WR_THRU is ignored.
- Counters saturate at all-ones and do not wrap.
- rst during RD_MISS/WR_THRU aborts immediately: mem_req drops asynchronously and no array write occurs.
- cpu_req low while stalled is a protocol error; the transaction still completes.

Optional Feature:
INVAL_SWEEP_EN

Defined:
- flush=1 in IDLE with no cpu_req enters SWEEP. If cpu_req is also high, the access is served first and flush must be held.
- SWEEP: arr_idx = sweep counter from 0 to 2**IDX_W-1, one per cycle; valid_we=1, valid_wdata=0; cpu_stall=1.
- After the last index, return to IDLE and clear the counter. Duration = 512 cycles.
- flush is ignored during the sweep.

Undefined:
- flush is ignored; invalidation comes only from the rst flash clear. The SWEEP state is absent.

Test Plan:
- Reset: rst=1 mid-sim -> all outputs 0, hit_cnt=miss_cnt=0; after release, load 0x0000_1004 misses (stall=1 immediately).
- Load miss/refill: load 0x0000_1004, mem_ack after 3 cycles with mem_rdata=0xDEADBEEF -> mem_req high 3 cycles, one cycle of valid/tag/data_we at idx 1, next cycle cpu_rdata=0xDEADBEEF, stall=0, miss_cnt=1, hit_cnt=1.
- Conflict: load 0x0000_1804 (same idx 1, different tag) -> miss and refill; reload 0x0000_1004 -> miss again.
- Store hit: store 0xCAFEF00D to 0x0000_1004 -> data_we in IDLE cycle, mem_we=1 until ack; then load returns 0xCAFEF00D with no stall.
- Store miss: store to 0x0000_2008 -> no array strobes, mem write only; subsequent load misses.
- Reset mid-miss, then sweep:
  - rst during RD_MISS -> mem_req drops, no array write.
  - With INVAL_SWEEP_EN: flush -> 512 stall cycles, valid_we each cycle; then load 0x0000_1004 misses.

Source files
------------

// File: rtl/cache_lookup_ctrl.sv
// Direct-mapped, single-word-line cache lookup/refill controller (write-through, no-write-allocate).
// Optional flush sweep of the valid array is enabled by defining INVAL_SWEEP_EN.
module cache_lookup_ctrl #(
  parameter int unsigned IDX_W = 9,
  parameter int unsigned TAG_W = 21,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  output logic [IDX_W-1:0] arr_idx,
  input  logic             valid_in,
  input  logic [TAG_W-1:0] tag_in,
  input  logic [31:0]      data_in,
  output logic             valid_we,
  output logic             valid_wdata,
  output logic             tag_we,
  output logic             data_we,
  output logic [TAG_W-1:0] tag_wdata,
  output logic [31:0]      data_wdata,
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic             mem_ack,
  input  logic [31:0]      mem_rdata,
  input  logic             flush,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_MISS = 2'd1;
  localparam logic [1:0] ST_WR_THRU = 2'd2;
`ifdef INVAL_SWEEP_EN
  localparam logic [1:0] ST_SWEEP   = 2'd3;
`endif

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic             hit_inc;
  logic             miss_inc;
  logic [IDX_W-1:0] addr_idx;
  logic [TAG_W-1:0] addr_tag;
  logic             hit;
  logic             unused_ok;

  assign addr_idx  = cpu_addr[2 +: IDX_W];
  assign addr_tag  = cpu_addr[IDX_W+2 +: TAG_W];
  assign hit       = valid_in & (tag_in == addr_tag);
  assign unused_ok = ^{flush, cpu_addr[1:0]};

`ifdef INVAL_SWEEP_EN
  logic [IDX_W-1:0] sweep_cnt;

  // Sweep index walks every entry once, then self-clears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sweep_cnt <= '0;
    end else if (state == ST_SWEEP) begin
      sweep_cnt <= (sweep_cnt == '1) ? '0 : sweep_cnt + IDX_W'(1);
    end
  end
`endif

  // State register and saturating performance counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      state <= next_state;
      if (hit_inc && (hit_cnt != '1)) begin
        hit_cnt <= hit_cnt + CNT_W'(1);
      end
      if (miss_inc && (miss_cnt != '1)) begin
        miss_cnt <= miss_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state and output decode; everything is forced low while rst is asserted.
  always_comb begin
    next_state  = state;
    hit_inc     = 1'b0;
    miss_inc    = 1'b0;
    cpu_rdata   = '0;
    cpu_stall   = 1'b0;
    arr_idx     = '0;
    valid_we    = 1'b0;
    valid_wdata = 1'b0;
    tag_we      = 1'b0;
    data_we     = 1'b0;
    tag_wdata   = '0;
    data_wdata  = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    if (!rst) begin
      arr_idx   = addr_idx;
      tag_wdata = addr_tag;
      mem_addr  = {cpu_addr[31:2], 2'b00};
      mem_wdata = cpu_wdata;
      case (state)
        ST_IDLE: begin
          if (cpu_req) begin
            if (cpu_we) begin
              cpu_stall  = 1'b1;
              data_we    = hit;
              data_wdata = cpu_wdata;
              next_state = ST_WR_THRU;
            end else if (hit) begin
              cpu_rdata = data_in;
              hit_inc   = 1'b1;
            end else begin
              cpu_stall  = 1'b1;
              miss_inc   = 1'b1;
              next_state = ST_RD_MISS;
            end
          end
`ifdef INVAL_SWEEP_EN
          else if (flush) begin
            next_state = ST_SWEEP;
          end
`endif
        end
        ST_RD_MISS: begin
          mem_req   = 1'b1;
          cpu_stall = 1'b1;
          if (mem_ack) begin
            valid_we    = 1'b1;
            valid_wdata = 1'b1;
            tag_we      = 1'b1;
            data_we     = 1'b1;
            data_wdata  = mem_rdata;
            next_state  = ST_IDLE;
          end
        end
        ST_WR_THRU: begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          cpu_stall = !mem_ack;
          if (mem_ack) begin
            next_state = ST_IDLE;
          end
        end
`ifdef INVAL_SWEEP_EN
        ST_SWEEP: begin
          arr_idx   = sweep_cnt;
          valid_we  = 1'b1;
          cpu_stall = 1'b1;
          if (sweep_cnt == '1) begin
            next_state = ST_IDLE;
          end
        end
`endif
        default: next_state = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_lookup_ctrl.sv
// Directed self-checking bench for cache_lookup_ctrl with a behavioural model of the three arrays.
// Define INVAL_SWEEP_EN for both files to exercise the flush sweep.
module tb_cache_lookup_ctrl;
  localparam int unsigned IDX_W = 9;
  localparam int unsigned TAG_W = 21;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             cpu_req, cpu_we;
  logic [31:0]      cpu_addr, cpu_wdata, cpu_rdata;
  logic             cpu_stall;
  logic [IDX_W-1:0] arr_idx;
  logic             valid_in;
  logic [TAG_W-1:0] tag_in;
  logic [31:0]      data_in;
  logic             valid_we, valid_wdata, tag_we, data_we;
  logic [TAG_W-1:0] tag_wdata;
  logic [31:0]      data_wdata;
  logic             mem_req, mem_we;
  logic [31:0]      mem_addr, mem_wdata;
  logic             mem_ack;
  logic [31:0]      mem_rdata;
  logic             flush;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cache_lookup_ctrl #(.IDX_W(IDX_W), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .arr_idx(arr_idx), .valid_in(valid_in), .tag_in(tag_in), .data_in(data_in),
    .valid_we(valid_we), .valid_wdata(valid_wdata), .tag_we(tag_we), .data_we(data_we),
    .tag_wdata(tag_wdata), .data_wdata(data_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .flush(flush), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Array model: combinational read, clocked write, valid flash-cleared by rst.
  logic             valid_a [512];
  logic [TAG_W-1:0] tag_a   [512];
  logic [31:0]      data_a  [512];

  assign valid_in = valid_a[arr_idx];
  assign tag_in   = tag_a[arr_idx];
  assign data_in  = data_a[arr_idx];

  initial begin
    for (int i = 0; i < 512; i++) begin
      tag_a[i]  = '0;
      data_a[i] = '0;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) valid_a[i] <= 1'b0;
    end else begin
      if (valid_we) valid_a[arr_idx] <= valid_wdata;
      if (tag_we)   tag_a[arr_idx]   <= tag_wdata;
      if (data_we)  data_a[arr_idx]  <= data_wdata;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load that misses: checks the stall, the req window and the refill strobes, ends in the hit cycle.
  task automatic miss_refill(input logic [31:0] addr, input int delay, input logic [31:0] rd,
                             input string tg);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
    #2;
    check({tg, "_miss_stall"}, 32'(cpu_stall), 32'd1);
    check({tg, "_idle_memreq"}, 32'(mem_req), 32'd0);
    for (int c = 1; c <= delay; c++) begin
      step();
      mem_ack = (c == delay); mem_rdata = rd;
      #2;
      check({tg, "_rd_req"}, {29'd0, mem_req, mem_we, cpu_stall}, 32'b101);
      check({tg, "_rd_addr"}, mem_addr, {addr[31:2], 2'b00});
      if (c == delay) begin
        check({tg, "_refill_we"}, {28'd0, valid_we, valid_wdata, tag_we, data_we}, 32'hF);
        check({tg, "_refill_data"}, data_wdata, rd);
        check({tg, "_refill_tag"}, 32'(tag_wdata), 32'(addr >> 11));
        check({tg, "_refill_idx"}, 32'(arr_idx), 32'((addr >> 2) & 32'h1FF));
      end else begin
        check({tg, "_wait_we"}, {29'd0, valid_we, tag_we, data_we}, 32'd0);
      end
    end
    step();
    mem_ack = 1'b0;
    #2;
    check({tg, "_rehit_stall"}, 32'(cpu_stall), 32'd0);
    check({tg, "_rehit_rdata"}, cpu_rdata, rd);
    check({tg, "_rehit_memreq"}, 32'(mem_req), 32'd0);
  endtask

  task automatic load_hit(input logic [31:0] addr, input logic [31:0] exp, input string tg);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
    #2;
    check({tg, "_hit_stall"}, 32'(cpu_stall), 32'd0);
    check({tg, "_hit_rdata"}, cpu_rdata, exp);
  endtask

  // Store: IDLE cycle (data_we only on hit), then write-through until ack; ends one cycle after ack.
  task automatic store(input logic [31:0] addr, input logic [31:0] wd, input logic is_hit,
                       input int delay, input string tg);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = addr; cpu_wdata = wd;
    #2;
    check({tg, "_idle_stall"}, 32'(cpu_stall), 32'd1);
    check({tg, "_idle_we"}, {29'd0, valid_we, tag_we, data_we}, {31'd0, is_hit});
    if (is_hit) check({tg, "_idle_wdata"}, data_wdata, wd);
    check({tg, "_idle_memreq"}, 32'(mem_req), 32'd0);
    for (int c = 1; c <= delay; c++) begin
      step();
      mem_ack = (c == delay);
      #2;
      check({tg, "_wt_req"}, {30'd0, mem_req, mem_we}, 32'b11);
      check({tg, "_wt_addr"}, mem_addr, {addr[31:2], 2'b00});
      check({tg, "_wt_wdata"}, mem_wdata, wd);
      check({tg, "_wt_stall"}, 32'(cpu_stall), 32'(c != delay));
      check({tg, "_wt_we"}, {29'd0, valid_we, tag_we, data_we}, 32'd0);
    end
    step();
    mem_ack = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    #2;
    check({tg, "_after_memreq"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1004; cpu_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", {26'd0, cpu_stall, mem_req, valid_we, tag_we, data_we, mem_we}, 32'd0);
    check("rst_idx", 32'(arr_idx), 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_cnts", {hit_cnt, miss_cnt}, 32'd0);
    rst = 1'b0;

    // Cold miss, ack on the third request cycle.
    miss_refill(32'h0000_1004, 3, 32'hDEAD_BEEF, "ld1");
    step();
    cpu_req = 1'b0;
    #2;
    check("ld1_hit_cnt", 32'(hit_cnt), 32'd1);
    check("ld1_miss_cnt", 32'(miss_cnt), 32'd1);

    // Conflict on index 1 evicts, then original address misses again.
    miss_refill(32'h0000_1804, 2, 32'h1111_2222, "ld2");
    step();
    miss_refill(32'h0000_1004, 1, 32'hDEAD_BEEF, "ld3");
    step();
    cpu_req = 1'b0;
    #2;
    check("conf_hit_cnt", 32'(hit_cnt), 32'd3);
    check("conf_miss_cnt", 32'(miss_cnt), 32'd3);

    // mem_ack while idle must do nothing.
    mem_ack = 1'b1;
    #1;
    check("stray_ack", {28'd0, mem_req, valid_we, tag_we, data_we}, 32'd0);
    step();
    mem_ack = 1'b0;
    #2;
    check("stray_ack_next", {30'd0, mem_req, cpu_stall}, 32'd0);

    // Store hit updates the array, then a load returns the new word with no stall.
    store(32'h0000_1004, 32'hCAFE_F00D, 1'b1, 2, "st1");
    step();
    load_hit(32'h0000_1004, 32'hCAFE_F00D, "ld_st1");
    step();
    cpu_req = 1'b0;
    #2;
    check("st1_hit_cnt", 32'(hit_cnt), 32'd4);

    // Store miss: memory write only, the next load still misses.
    store(32'h0000_2008, 32'h55AA_55AA, 1'b0, 1, "st2");
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_2008;
    #2;
    check("st2_ld_miss", 32'(cpu_stall), 32'd1);
    step();
    #2;
    check("rdmiss_req", 32'(mem_req), 32'd1);
    check("rdmiss_cnt", 32'(miss_cnt), 32'd4);

    // Reset in the middle of a refill, with an ack arriving at the same time.
    #1;
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h0BAD_0BAD;
    #1;
    check("rst_mid_req", {28'd0, mem_req, cpu_stall, mem_we, 1'b0}, 32'd0);
    check("rst_mid_we", {29'd0, valid_we, tag_we, data_we}, 32'd0);
    check("rst_mid_cnts", {hit_cnt, miss_cnt}, 32'd0);
    step();
    rst = 1'b0; mem_ack = 1'b0;
    miss_refill(32'h0000_1004, 2, 32'h0BAD_F00D, "ld4");
    step();
    cpu_req = 1'b0;
    #2;
    check("ld4_cnts", {hit_cnt, miss_cnt}, {16'd1, 16'd1});

`ifdef INVAL_SWEEP_EN
    begin
      int ok;
      ok = 0;
      step();
      flush = 1'b1;
      #2;
      check("flush_idle_stall", 32'(cpu_stall), 32'd0);
      step();
      for (int i = 0; i < 512; i++) begin
        #2;
        if (cpu_stall && valid_we && !valid_wdata && !tag_we && !data_we && (32'(arr_idx) == i)) ok++;
        if (i == 8) flush = 1'b0;
        step();
      end
      check("sweep_cycles", ok, 32'd512);
      #2;
      check("sweep_done_we", 32'(valid_we), 32'd0);
      miss_refill(32'h0000_1004, 1, 32'h1357_9BDF, "ld5");
      step();
      cpu_req = 1'b0;
      #2;
      check("ld5_miss_cnt", 32'(miss_cnt), 32'd2);
    end
`else
    step();
    flush = 1'b1;
    #2;
    check("flush_idle_stall", 32'(cpu_stall), 32'd0);
    step();
    #2;
    check("flush_ignored", {30'd0, valid_we, cpu_stall}, 32'd0);
    flush = 1'b0;
    load_hit(32'h0000_1004, 32'h0BAD_F00D, "ld5");
    step();
    cpu_req = 1'b0;
    #2;
    check("ld5_miss_cnt", 32'(miss_cnt), 32'd1);
`endif

    // Saturation: far more hits than the counter can hold.
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1004;
    repeat (65540) @(posedge clk);
    #1;
    #2;
    check("sat_still_hit", 32'(cpu_stall), 32'd0);
    cpu_req = 1'b0;
    step();
    #2;
    check("hit_cnt_sat", 32'(hit_cnt), 32'h0000_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
